// File: rtl/prince_decrypt_core_pkg.sv
// PRINCE constants, state/layer-order enums and the bit-level layer functions
// shared by the round logic and the core.
package prince_decrypt_core_pkg;

    localparam logic [63:0] ALPHA    = 64'hc0ac29b7c97c50dd;
    localparam logic [3:0]  LAST_RND = 4'd11;
    localparam logic [3:0]  MID_RND  = 4'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {ORD_FWD, ORD_MID, ORD_INV} ord_e;

    localparam logic [3:0] SBOX [16] = '{4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4};
    localparam logic [3:0] SINV [16] = '{4'hb, 4'h7, 4'h3, 4'h2, 4'hf, 4'hd, 4'h8, 4'h9,
                                         4'ha, 4'h6, 4'h4, 4'h0, 4'h5, 4'he, 4'hc, 4'h1};
    // Nibble 0 is the most significant nibble; SR_IDX[i] is the source of output nibble i.
    localparam int SR_IDX [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    function automatic logic [63:0] rc(input logic [3:0] idx);
        case (idx)
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] k0_prime(input logic [63:0] k0);
        return {k0[0], k0[63:2], k0[1] ^ k0[63]};
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = SBOX[x[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [63:0] sinv_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = SINV[x[4*i +: 4]];
        return r;
    endfunction

    // 16x16 block of M': row block br uses M_{(br+bc+sel)%4}, where M_j is identity minus bit j.
    function automatic logic [15:0] mhat(input logic [15:0] x, input int sel);
        logic [15:0] r;
        r = '0;
        for (int br = 0; br < 4; br++)
            for (int j = 0; j < 4; j++)
                for (int bc = 0; bc < 4; bc++)
                    if (((br + bc + sel) % 4) != j)
                        r[15 - (4*br + j)] = r[15 - (4*br + j)] ^ x[15 - (4*bc + j)];
        return r;
    endfunction

    function automatic logic [63:0] mprime(input logic [63:0] x);
        return {mhat(x[63:48], 0), mhat(x[47:32], 1), mhat(x[31:16], 1), mhat(x[15:0], 0)};
    endfunction

    function automatic logic [63:0] sr(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[60 - 4*i +: 4] = x[60 - 4*SR_IDX[i] +: 4];
        return r;
    endfunction

    function automatic logic [63:0] srinv(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[60 - 4*SR_IDX[i] +: 4] = x[60 - 4*i +: 4];
        return r;
    endfunction

endpackage

// File: rtl/prince_round_logic.sv
// Combinational PRINCE round: one shared M' layer, with the S/SR order chosen
// for forward, middle or inverse rounds.
module prince_round_logic
    import prince_decrypt_core_pkg::*;
(
    input  logic [63:0] st,
    input  logic [63:0] add,
    input  ord_e        ord,
    output logic [63:0] nxt
);

    logic [63:0] pre;
    logic [63:0] mp_in;
    logic [63:0] mp;

    // Forward: SR(M'(S(st)))^add; middle: Sinv(M'(S(st))); inverse: Sinv(M'(SRinv(st^add))).
    always_comb begin
        pre   = (ord == ORD_INV) ? (st ^ add) : st;
        mp_in = (ord == ORD_INV) ? srinv(pre) : sbox_layer(pre);
        mp    = mprime(mp_in);
        nxt   = (ord == ORD_FWD) ? (sr(mp) ^ add) : sinv_layer(mp);
    end

endmodule

// File: rtl/prince_decrypt_core.sv
// Round-based PRINCE decryption core, one round per clock, valid/ready on both sides.
// Defining PRINCE_ENCDEC_EN adds a `mode` input (1 = encrypt) sampled on the accept edge.
module prince_decrypt_core
    import prince_decrypt_core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  din,
    input  logic [127:0] key,
`ifdef PRINCE_ENCDEC_EN
    input  logic         mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  dout
);

    state_e      state, state_nxt;
    logic [3:0]  rnd;
    logic [63:0] st, kc, wout;
    logic [63:0] win_in, wout_in, kc_in;
    logic [63:0] add, rnd_out;
    logic [3:0]  rc_idx;
    ord_e        ord;
    logic        enc, accept, last;

`ifdef PRINCE_ENCDEC_EN
    assign enc = mode;
`else
    assign enc = 1'b0;
`endif

    // Alpha-reflection: decryption is encryption with swapped whitening keys and k1^ALPHA.
    assign win_in  = enc ? key[127:64] : k0_prime(key[127:64]);
    assign wout_in = enc ? k0_prime(key[127:64]) : key[127:64];
    assign kc_in   = enc ? key[63:0] : (key[63:0] ^ ALPHA);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = (state == IDLE) && in_valid;
    assign last      = (state == RUN) && (rnd == LAST_RND);

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (rnd == LAST_RND) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ord    = ORD_INV;
        rc_idx = rnd - 4'd1;
        if (rnd < MID_RND) begin
            ord    = ORD_FWD;
            rc_idx = rnd;
        end else if (rnd == MID_RND) begin
            ord    = ORD_MID;
            rc_idx = rnd;
        end
    end

    assign add = rc(rc_idx) ^ kc;

    prince_round_logic u_round (
        .st  (st),
        .add (add),
        .ord (ord),
        .nxt (rnd_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rnd   <= '0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                rnd <= 4'd1;
            else if (state == RUN)
                rnd <= last ? 4'd0 : rnd + 4'd1;
            if (last)
                dout <= rnd_out ^ rc(LAST_RND) ^ kc ^ wout;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            st   <= din ^ win_in ^ kc_in ^ rc(4'd0);
            kc   <= kc_in;
            wout <= wout_in;
        end else if (state == RUN) begin
            st <= rnd_out;
        end
    end

endmodule

// File: tb/tb_prince_decrypt_core.sv
// Directed bench for prince_decrypt_core: published PRINCE vectors, latency,
// output hold under back-pressure, mid-run reset abort and ignored in_valid pulses.
module tb_prince_decrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  din;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  dout;
`ifdef PRINCE_ENCDEC_EN
    logic         mode;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prince_decrypt_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
`ifdef PRINCE_ENCDEC_EN
        .mode      (mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one block: accept, count edges to out_valid, optional back-pressure hold, release.
    task automatic run_op(input string tag, input logic [63:0] c, input logic [127:0] k,
                          input logic [63:0] exp, input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        din      = c;
        key      = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        din      = ~c;
        key      = ~k;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            in_valid = pulse && lat[0];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, 64'(lat), 64'd11);
        check({tag, ":dout"}, dout, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ":hold_dout"}, dout, exp);
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ":in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        key       = '0;
`ifdef PRINCE_ENCDEC_EN
        mode      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset:in_ready", 64'(in_ready), 64'd1);
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:dout", dout, 64'd0);
        reset = 1'b1;

        run_op("v1", 64'h818665aa0d02dfda, {64'h0, 64'h0}, 64'h0000000000000000, 0, 1'b0);
        run_op("v2", 64'h604ae6ca03c20ada, {64'h0, 64'h0}, 64'hffffffffffffffff, 0, 1'b0);
        run_op("v3a", 64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'h0}, 64'h0, 0, 1'b0);
        run_op("v3b", 64'h78a54cbe737bb7ef, {64'h0, 64'hffffffffffffffff}, 64'h0, 0, 1'b0);
        run_op("v4", 64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210},
               64'h0123456789abcdef, 5, 1'b0);

        // Abort at rnd 6: accept, then five more edges before reset is sampled.
        @(negedge clk);
        check("abort:in_ready_idle", 64'(in_ready), 64'd1);
        din      = 64'h818665aa0d02dfda;
        key      = '0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort:running", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort:out_valid", 64'(out_valid), 64'd0);
        check("abort:in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;

        run_op("v1_after_abort", 64'h818665aa0d02dfda, {64'h0, 64'h0}, 64'h0, 0, 1'b1);

`ifdef PRINCE_ENCDEC_EN
        mode = 1'b1;
        run_op("enc", 64'h0123456789abcdef, {64'h0, 64'hfedcba9876543210},
               64'hae25ad3ca8fa9ccf, 0, 1'b0);
        mode = 1'b0;
        run_op("dec_back", 64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210},
               64'h0123456789abcdef, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
